scan_decoder: RTL and testbench
===============================

// Module: scan_decoder
// PURPOSE
//  Registered, parametrised N-to-2^N decoder with 74x138-style enables (G, GA, GB) and two modes.
//  Direct mode decodes the A input. Scan mode cycles through every output on an internal prescaled
//  counter, for multiplexed digit/LED select lines.
//  Sits between control logic and display/row-select drivers.
// PARAMETERS
//  AW          3   address width; output width is 2**AW (AW >= 1)
//  DIV         4   clock cycles per scan step (DIV >= 1; prescaler width = max(1, clog2(DIV)))
//  ACTIVE_LOW  1   1: selected output 0 and idle 1 (138 style); 0: selected output 1 and idle 0
// PORTS
//  CLK   in   1       clock, rising edge
//  RST   in   1       synchronous reset, active-high
//  G     in   1       enable, active-high
//  GA    in   1       enable, active-low
//  GB    in   1       enable, active-low
//  MODE  in   1       0 = direct decode of A, 1 = auto scan
//  LOAD  in   1       scan mode only: load scan index from A
//  A     in   AW      address (direct) / load value (scan)
//  Y     out  2**AW   registered decoded outputs
//  CUR   out  AW      registered index currently driven on Y
//  WRAP  out  1       one-cycle pulse when a scan step wraps CUR from 2**AW-1 to 0
// BEHAVIOUR
//  - One clock domain (CLK). RST is synchronous and active-high; it has priority over all other inputs.
//  - Reset values: Y = idle (all 1s if ACTIVE_LOW, else all 0s), CUR = 0, prescaler = 0, WRAP = 0.
//  - EN = G & ~GA & ~GB, sampled each rising edge.
//  - DEC(i): a one-hot value with bit i set, inverted when ACTIVE_LOW = 1. IDLE: all bits inactive.
//  - All outputs are registered. Latency from input to Y/CUR is 1 cycle.
//  - Y always equals DEC(CUR) when EN was 1 at the last edge, and IDLE otherwise.
//  - Direct mode (MODE = 0):
//    EN = 1: CUR <= A, Y <= DEC(A).
//    EN = 0: CUR holds, Y <= IDLE.
//    Prescaler is forced to 0. LOAD is ignored. WRAP <= 0.
//  - Scan mode (MODE = 1). Priority: RST > ~EN > LOAD > step.
//    EN = 0: CUR and prescaler freeze, Y <= IDLE, WRAP <= 0.
//    EN = 1 and LOAD = 1: CUR <= A, prescaler <= 0, Y <= DEC(A), WRAP <= 0.
//    EN = 1, LOAD = 0, prescaler < DIV-1: prescaler increments; CUR holds; Y <= DEC(CUR).
//    EN = 1, LOAD = 0, prescaler = DIV-1: prescaler <= 0, CUR <= CUR+1 (mod 2**AW), Y <= DEC(CUR+1).
//    On a step from CUR = 2**AW-1 to 0, WRAP <= 1 for that cycle only. WRAP is never set by LOAD.
//  - DIV = 1: CUR steps every enabled cycle; the prescaler stays at 0.
//  - Mode switch 0->1: scan starts from the held CUR with prescaler = 0.
//    The first step occurs DIV enabled cycles later.
//  - Mode switch 1->0: the next edge performs a direct decode; the prescaler is cleared.
//  - Reset asserted mid-scan: all state returns to reset values on that edge.
//    With MODE = 1 and EN = 1, the scan restarts from index 0 after RST deasserts.
// TESTING
//  1 RST = 1 for 2 cycles, any inputs -> Y = 8'hFF, CUR = 0, WRAP = 0.
//  2 Direct mode: G = 1, GA = 0, GB = 0, MODE = 0, A = 3'd5 -> next edge Y = 8'b11011_111, CUR = 5.
//    Then GA = 1 -> Y = 8'hFF, CUR = 5.
//  3 Scan mode, DIV = 4, from reset with EN = 1 and MODE = 1:
//    Y steps FE, FD, FB, F7, EF, DF, BF, 7F, holding each value 4 cycles.
//    At cycle 32 CUR = 0, Y = FE, and WRAP = 1 for exactly 1 cycle.
//  4 Scan mode, LOAD = 1 with A = 3'd6 while the prescaler is 2 -> next edge CUR = 6, Y = 8'hBF,
//    WRAP = 0. 4 cycles later CUR = 7 and Y = 8'h7F.
//  5 Scan mode at CUR = 3, prescaler = 1; GB = 1 for 3 cycles -> Y = FF, CUR = 3, prescaler frozen.
//    After GB = 0: Y = F7, and the step to 4 comes 3 enabled cycles later.
//  6 ACTIVE_LOW = 0, AW = 4, DIV = 1, scan mode:
//    Y walks 16'h0001 .. 16'h8000 on consecutive cycles; WRAP pulses every 16 cycles.
//    RST mid-walk -> Y = 16'h0000, CUR = 0.

Source files
------------

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered N-to-2^N decoder with 138-style enables and auto-scan mode
//
// Decodes an AW-bit index onto 2**AW select lines. In direct mode (MODE = 0)
// the index comes from A. In scan mode (MODE = 1) an internal prescaled counter
// walks every output in turn, for multiplexed digit/LED select lines.
//
// Ports:
//   CLK   in   1      clock, rising edge
//   RST   in   1      synchronous reset, active-high, highest priority
//   G     in   1      enable, active-high
//   GA    in   1      enable, active-low
//   GB    in   1      enable, active-low
//   MODE  in   1      0 = direct decode of A, 1 = auto scan
//   LOAD  in   1      scan mode: load scan index from A
//   A     in   AW     address (direct) / load value (scan)
//   Y     out  2**AW  registered decoded outputs
//   CUR   out  AW     registered index currently driven on Y
//   WRAP  out  1      one-cycle pulse when a scan step wraps CUR to 0
module scan_decoder #(
    parameter int AW         = 3,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               G,
    input  logic               GA,
    input  logic               GB,
    input  logic               MODE,
    input  logic               LOAD,
    input  logic [AW-1:0]      A,
    output logic [2**AW-1:0]   Y,
    output logic [AW-1:0]      CUR,
    output logic               WRAP
);

    localparam int NO = 2**AW;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);
    localparam logic [NO-1:0] IDLE    = ACTIVE_LOW ? {NO{1'b1}} : {NO{1'b0}};

    logic            en;
    logic [PW-1:0]   ps;
    logic [PW-1:0]   ps_nxt;
    logic [AW-1:0]   cur_nxt;
    logic            wrap_nxt;
    logic [NO-1:0]   y_nxt;

    function automatic logic [NO-1:0] dec(input logic [AW-1:0] idx);
        logic [NO-1:0] oh;
        oh = NO'(1) << idx;
        return ACTIVE_LOW ? ~oh : oh;
    endfunction

    assign en = G & ~GA & ~GB;

    always_comb begin
        cur_nxt  = CUR;
        ps_nxt   = ps;
        wrap_nxt = 1'b0;
        if (!MODE) begin
            // Direct mode keeps the prescaler cleared so a later switch to
            // scan always starts a full DIV-cycle step from the held index.
            ps_nxt = '0;
            if (en) begin
                cur_nxt = A;
            end
        end else if (en) begin
            if (LOAD) begin
                cur_nxt = A;
                ps_nxt  = '0;
            end else if (ps == PS_LAST) begin
                ps_nxt   = '0;
                cur_nxt  = CUR + AW'(1);
                wrap_nxt = (CUR == {AW{1'b1}});
            end else begin
                ps_nxt = ps + PW'(1);
            end
        end
        // Disabled scan freezes CUR and prescaler (defaults above).
        y_nxt = en ? dec(cur_nxt) : IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Y    <= IDLE;
            CUR  <= '0;
            ps   <= '0;
            WRAP <= 1'b0;
        end else begin
            Y    <= y_nxt;
            CUR  <= cur_nxt;
            ps   <= ps_nxt;
            WRAP <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - randomized and directed bench for scan_decoder against a behavioural model
module tb_scan_decoder;

    logic        clk = 1'b0;
    logic        rst, g, ga, gb, mode, load;
    logic [3:0]  a_in;
    logic [7:0]  y_a;
    logic [2:0]  cur_a;
    logic        wrap_a;
    logic [15:0] y_b;
    logic [3:0]  cur_b;
    logic        wrap_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: 0 = default params, 1 = AW 4 / DIV 1 / active-high
    int m_cur[2];
    int m_ps[2];
    int m_wrap[2];
    int m_y[2];

    always #5 clk = ~clk;

    scan_decoder #(.AW(3), .DIV(4), .ACTIVE_LOW(1'b1)) dut_a (
        .CLK(clk), .RST(rst), .G(g), .GA(ga), .GB(gb), .MODE(mode), .LOAD(load),
        .A(a_in[2:0]), .Y(y_a), .CUR(cur_a), .WRAP(wrap_a)
    );

    scan_decoder #(.AW(4), .DIV(1), .ACTIVE_LOW(1'b0)) dut_b (
        .CLK(clk), .RST(rst), .G(g), .GA(ga), .GB(gb), .MODE(mode), .LOAD(load),
        .A(a_in), .Y(y_b), .CUR(cur_b), .WRAP(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int sel_val(int nout, int al, int c);
        int oh;
        oh = 1 << c;
        return al ? (((1 << nout) - 1) ^ oh) : oh;
    endfunction

    task automatic model_step(input int k);
        int nout, div, al, en;
        nout = (k == 0) ? 8 : 16;
        div  = (k == 0) ? 4 : 1;
        al   = (k == 0) ? 1 : 0;
        if (rst) begin
            m_cur[k]  = 0;
            m_ps[k]   = 0;
            m_wrap[k] = 0;
            m_y[k]    = al ? (1 << nout) - 1 : 0;
        end else begin
            en = (g && !ga && !gb) ? 1 : 0;
            m_wrap[k] = 0;
            if (!mode) begin
                m_ps[k] = 0;
                if (en != 0) m_cur[k] = int'(a_in) % nout;
            end else if (en != 0) begin
                if (load) begin
                    m_cur[k] = int'(a_in) % nout;
                    m_ps[k]  = 0;
                end else if (m_ps[k] == div - 1) begin
                    m_ps[k] = 0;
                    if (m_cur[k] == nout - 1) m_wrap[k] = 1;
                    m_cur[k] = (m_cur[k] + 1) % nout;
                end else begin
                    m_ps[k]++;
                end
            end
            m_y[k] = (en != 0) ? sel_val(nout, al, m_cur[k]) : (al ? (1 << nout) - 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check("a_y",    32'(y_a),    32'(m_y[0]));
        check("a_cur",  32'(cur_a),  32'(m_cur[0]));
        check("a_wrap", 32'(wrap_a), 32'(m_wrap[0]));
        check("b_y",    32'(y_b),    32'(m_y[1]));
        check("b_cur",  32'(cur_b),  32'(m_cur[1]));
        check("b_wrap", 32'(wrap_b), 32'(m_wrap[1]));
    endtask

    task automatic drive(input logic r, input logic g_i, input logic ga_i, input logic gb_i,
                         input logic mode_i, input logic load_i, input logic [3:0] a_i);
        rst  = r;
        g    = g_i;
        ga   = ga_i;
        gb   = gb_i;
        mode = mode_i;
        load = load_i;
        a_in = a_i;
        tick();
    endtask

    initial begin
        logic [7:0] exp8;

        // Reset for two cycles with arbitrary other inputs
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom));
        end
        check("rst_y_a", 32'(y_a), 32'hFF);
        check("rst_cur_a", 32'(cur_a), 32'd0);
        check("rst_wrap_a", 32'(wrap_a), 32'd0);
        check("rst_y_b", 32'(y_b), 32'h0000);

        // Direct decode, then disable via GA
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        check("dir_y", 32'(y_a), 32'hDF);
        check("dir_cur", 32'(cur_a), 32'd5);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        check("dir_dis_y", 32'(y_a), 32'hFF);
        check("dir_dis_cur", 32'(cur_a), 32'd5);

        // Scan from reset: 4 cycles per step, wrap at cycle 32
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 1; i <= 33; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            exp8 = ~(8'd1 << ((i / 4) % 8));
            check("scan_y", 32'(y_a), 32'(exp8));
            check("scan_wrap", 32'(wrap_a), (i == 32) ? 32'd1 : 32'd0);
            check("walk_y", 32'(y_b), 32'(16'd1 << (i % 16)));
            check("walk_wrap", 32'(wrap_b), (i == 16 || i == 32) ? 32'd1 : 32'd0);
        end

        // Prescaler is 1 here; one more cycle makes it 2, then LOAD 6
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6);
        check("load_cur", 32'(cur_a), 32'd6);
        check("load_y", 32'(y_a), 32'hBF);
        check("load_wrap", 32'(wrap_a), 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("load_step_cur", 32'(cur_a), 32'd7);
        check("load_step_y", 32'(y_a), 32'h7F);

        // CUR 3, prescaler 1, then freeze with GB for 3 cycles
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            check("frz_y", 32'(y_a), 32'hFF);
            check("frz_cur", 32'(cur_a), 32'd3);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("thaw_y", 32'(y_a), 32'hF7);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("thaw_cur", 32'(cur_a), 32'd3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("thaw_step", 32'(cur_a), 32'd4);

        // Reset mid-walk
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("midrst_y_b", 32'(y_b), 32'h0000);
        check("midrst_cur_b", 32'(cur_b), 32'd0);

        // Randomized traffic, biased toward enabled scanning
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0),
                  4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
